// File: rtl/usb_handshake_tx.sv
// Bit-serial USB handshake transmitter (SYNC, PID, EOP, J); define USB_HS_TX_NRZI_EN to NRZI-encode txBit.
// Latency: busy rises 1 clock after acceptance; the line starts on the first bitStrobe after that.
// Backpressure: none; sendReq while busy or during the done pulse is dropped, never queued.
module usb_handshake_tx #(
    parameter int SYNC_LEN = 8,
    parameter int EOP_BITS = 2
) (
    input  logic       useClk,
    input  logic       nRst,
    input  logic       bitStrobe,
    input  logic       sendReq,
    input  logic [1:0] pidSel,
    output logic       busy,
    output logic       txBit,
    output logic       txOE,
    output logic       txEop,
    output logic       done
);
    localparam int CW = $clog2(SYNC_LEN + 8 + EOP_BITS + 1) + 1;
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] SYNC_PRE  = CW'(SYNC_LEN - 2);
    localparam logic [CW-1:0] PID_LAST  = CW'(7);
    localparam logic [CW-1:0] EOP_LAST  = CW'(EOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_SYNC, S_PID, S_EOP, S_JBIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pid_q, pid_d;
    logic          busy_q, busy_d;
    logic          bit_q, bit_d;
    logic          oe_q, oe_d;
    logic          eop_q, eop_d;
    logic          done_q, done_d;
    logic          accept;
    logic          load_bit;
    logic          data_bit;
    logic [2:0]    pid_idx;

    // done_q blocks acceptance so a request coincident with the done pulse is dropped
    assign accept  = sendReq && !busy_q && !done_q && (state_q == S_IDLE);
    assign pid_idx = cnt_q[2:0] + 3'd1;

    always_ff @(posedge useClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pid_q   <= '0;
            busy_q  <= 1'b0;
            bit_q   <= 1'b1;
            oe_q    <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pid_q   <= pid_d;
            busy_q  <= busy_d;
            bit_q   <= bit_d;
            oe_q    <= oe_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pid_d   = pid_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_ARMED;
                cnt_d   = '0;
                case (pidSel)
                    2'b00:   pid_d = 8'hD2;
                    2'b01:   pid_d = 8'h5A;
                    2'b10:   pid_d = 8'h1E;
                    default: pid_d = 8'h96;
                endcase
            end
            S_ARMED: if (bitStrobe) begin
                state_d = S_SYNC;
                cnt_d   = '0;
            end
            S_SYNC: if (bitStrobe) begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = S_PID;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PID: if (bitStrobe) begin
                if (cnt_q == PID_LAST) begin
                    state_d = S_EOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EOP: if (bitStrobe) begin
                if (cnt_q == EOP_LAST) begin
                    state_d = S_JBIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_JBIT: if (bitStrobe) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_d   = busy_q;
        bit_d    = bit_q;
        oe_d     = oe_q;
        eop_d    = eop_q;
        done_d   = 1'b0;
        load_bit = 1'b0;
        data_bit = 1'b0;
        case (state_q)
            S_IDLE: if (accept) busy_d = 1'b1;
            S_ARMED: if (bitStrobe) begin
                oe_d     = 1'b1;
                load_bit = 1'b1;
            end
            S_SYNC: if (bitStrobe) begin
                load_bit = 1'b1;
                data_bit = (cnt_q == SYNC_LAST) ? pid_q[0] : (cnt_q == SYNC_PRE);
            end
            S_PID: if (bitStrobe) begin
                if (cnt_q == PID_LAST) begin
                    eop_d = 1'b1;
                end else begin
                    load_bit = 1'b1;
                    data_bit = pid_q[pid_idx];
                end
            end
            S_EOP: if (bitStrobe && (cnt_q == EOP_LAST)) begin
                eop_d = 1'b0;
                bit_d = 1'b1;
            end
            S_JBIT: if (bitStrobe) begin
                oe_d   = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
                bit_d  = 1'b1;
            end
            default: ;
        endcase
        // bit_q doubles as the NRZI line level; JBIT and reset bring it back to 1
        if (load_bit) begin
`ifdef USB_HS_TX_NRZI_EN
            bit_d = data_bit ? bit_q : ~bit_q;
`else
            bit_d = data_bit;
`endif
        end
    end

    assign busy  = busy_q;
    assign txBit = bit_q;
    assign txOE  = oe_q;
    assign txEop = eop_q;
    assign done  = done_q;
endmodule

// File: tb/tb_usb_handshake_tx.sv
// Bench for usb_handshake_tx: default instance and a SYNC_LEN=32/EOP_BITS=3 instance share stimulus;
// expected per-strobe line values are queued on acceptance and compared as strobes occur.
module tb_usb_handshake_tx;
    typedef struct packed {
        logic b;
        logic e;
        logic o;
        logic bz;
        logic d;
    } rec_t;

    logic       clk = 1'b0;
    logic       nRst;
    logic       bitStrobe;
    logic       sendReq;
    logic [1:0] pidSel;
    logic       busy_a, txBit_a, txOE_a, txEop_a, done_a;
    logic       busy_b, txBit_b, txOE_b, txEop_b, done_b;

    int   total = 0;
    int   bad = 0;
    int   dones_a = 0;
    int   dones_b = 0;
    int   exp_pkts = 0;
    int   phase = 0;
    logic seen_eop = 1'b0;
    logic req_jbit = 1'b0;
    logic req_done = 1'b0;
    rec_t qa[$];
    rec_t qb[$];

    always #5 clk = ~clk;

    usb_handshake_tx dut_a (
        .useClk(clk), .nRst(nRst), .bitStrobe(bitStrobe), .sendReq(sendReq), .pidSel(pidSel),
        .busy(busy_a), .txBit(txBit_a), .txOE(txOE_a), .txEop(txEop_a), .done(done_a)
    );

    usb_handshake_tx #(.SYNC_LEN(32), .EOP_BITS(3)) dut_b (
        .useClk(clk), .nRst(nRst), .bitStrobe(bitStrobe), .sendReq(sendReq), .pidSel(pidSel),
        .busy(busy_b), .txBit(txBit_b), .txOE(txOE_b), .txEop(txEop_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input bit ib, input rec_t r);
        if (ib) qb.push_back(r);
        else    qa.push_back(r);
    endtask

    task automatic push_pkt(input bit ib, input logic [1:0] sel);
        int sl;
        int eb;
        logic [7:0] pid;
        logic lvl;
        logic d;
        sl = ib ? 32 : 8;
        eb = ib ? 3 : 2;
        case (sel)
            2'b00:   pid = 8'hD2;
            2'b01:   pid = 8'h5A;
            2'b10:   pid = 8'h1E;
            default: pid = 8'h96;
        endcase
        lvl = 1'b1;
        for (int i = 0; i < sl + 8; i++) begin
            d = (i < sl) ? (i == sl - 1) : pid[i - sl];
`ifdef USB_HS_TX_NRZI_EN
            if (!d) lvl = ~lvl;
`else
            lvl = d;
`endif
            push(ib, '{b: lvl, e: 1'b0, o: 1'b1, bz: 1'b1, d: 1'b0});
        end
        for (int i = 0; i < eb; i++) push(ib, '{b: lvl, e: 1'b1, o: 1'b1, bz: 1'b1, d: 1'b0});
        push(ib, '{b: 1'b1, e: 1'b0, o: 1'b1, bz: 1'b1, d: 1'b0});
        push(ib, '{b: 1'b1, e: 1'b0, o: 1'b0, bz: 1'b0, d: 1'b1});
    endtask

    task automatic mon(input bit ib, input rec_t act);
        rec_t e;
        if ((ib ? qb.size() : qa.size()) != 0) begin
            e = ib ? qb.pop_front() : qa.pop_front();
            chk(ib ? "B txBit" : "A txBit", act.b,  e.b);
            chk(ib ? "B txEop" : "A txEop", act.e,  e.e);
            chk(ib ? "B txOE"  : "A txOE",  act.o,  e.o);
            chk(ib ? "B busy"  : "A busy",  act.bz, e.bz);
            chk(ib ? "B done"  : "A done",  act.d,  e.d);
        end else begin
            chk(ib ? "B idle txOE" : "A idle txOE", act.o, 1'b0);
            chk(ib ? "B idle txEop" : "A idle txEop", act.e, 1'b0);
        end
    endtask

    initial begin : monitor
        logic st;
        forever begin
            @(posedge clk);
            st = bitStrobe;
            #1;
            if (done_a) dones_a++;
            if (done_b) dones_b++;
            if (st && nRst) begin
                mon(1'b0, '{b: txBit_a, e: txEop_a, o: txOE_a, bz: busy_a, d: done_a});
                mon(1'b1, '{b: txBit_b, e: txEop_b, o: txOE_b, bz: busy_b, d: done_b});
            end
        end
    end

    task automatic step(input logic req);
        @(negedge clk);
        if (txEop_a) seen_eop = 1'b1;
        phase = (phase + 1) % 4;
        bitStrobe = (phase == 0);
        sendReq = req
               || (req_jbit && bitStrobe && seen_eop && txOE_a && !txEop_a)
               || (req_done && done_a);
    endtask

    task automatic send(input logic [1:0] sel);
        pidSel = sel;
        step(1'b1);
        seen_eop = 1'b0;
        @(posedge clk);
        #2;
        sendReq = 1'b0;
        push_pkt(1'b0, sel);
        push_pkt(1'b1, sel);
        exp_pkts++;
        chk("busy after accept", busy_a, 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < limit) begin
            step(1'b0);
            n++;
        end
        chk("packet timeout", (n < limit), 1'b1);
        req_jbit = 1'b0;
        req_done = 1'b0;
    endtask

    initial begin
        int n;
        nRst = 1'b0;
        bitStrobe = 1'b0;
        sendReq = 1'b0;
        pidSel = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst busy", busy_a, 1'b0);
        chk("rst txBit", txBit_a, 1'b1);
        chk("rst txOE", txOE_a, 1'b0);
        chk("rst txEop", txEop_a, 1'b0);
        chk("rst done", done_a, 1'b0);
        chk("rst B txBit", txBit_b, 1'b1);
        nRst = 1'b1;
        repeat (2) step(1'b0);

        send(2'b01);
        wait_idle(600);
        send(2'b00);
        wait_idle(600);
        send(2'b10);
        wait_idle(600);

        // stray requests with changing pidSel mid-packet, in the JBIT strobe cycle and in the done cycle
        send(2'b11);
        for (int i = 0; i < 30; i++) begin
            pidSel = 2'(i);
            step(i % 7 == 3);
        end
        req_jbit = 1'b1;
        req_done = 1'b1;
        wait_idle(600);
        repeat (8) step(1'b0);

        // abort while A drives PID bit 3
        send(2'b01);
        n = 0;
        while (qa.size() > 8 && n < 200) begin
            step(1'b0);
            n++;
        end
        chk("reach PID bit3", (n < 200), 1'b1);
        #2;
        nRst = 1'b0;
        #1;
        chk("abort txOE", txOE_a, 1'b0);
        chk("abort txBit", txBit_a, 1'b1);
        chk("abort busy", busy_a, 1'b0);
        chk("abort txEop", txEop_a, 1'b0);
        chk("abort B txOE", txOE_b, 1'b0);
        chk("abort B busy", busy_b, 1'b0);
        qa.delete();
        qb.delete();
        exp_pkts--;
        repeat (3) step(1'b0);
        nRst = 1'b1;
        repeat (6) step(1'b0);
        chk("abort no done", done_a, 1'b0);

        send(2'b01);
        wait_idle(600);
        repeat (4) step(1'b0);

        chk("A done count", dones_a, exp_pkts);
        chk("B done count", dones_b, exp_pkts);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
